// File: rtl/alu_pkg.sv
// Shared function codes and FSM encoding for the multi-cycle ALU.
// The control decoder imports the function codes from here as well.
package alu_pkg;

   localparam logic [3:0] FN_AND  = 4'b0000;
   localparam logic [3:0] FN_OR   = 4'b0001;
   localparam logic [3:0] FN_XOR  = 4'b0010;
   localparam logic [3:0] FN_NOR  = 4'b0011;
   localparam logic [3:0] FN_SLT  = 4'b0100;
   localparam logic [3:0] FN_NAND = 4'b0101;
   localparam logic [3:0] FN_ADD  = 4'b1000;
   localparam logic [3:0] FN_SUB  = 4'b1001;
   localparam logic [3:0] FN_MUL  = 4'b1010;
   localparam logic [3:0] FN_DIV  = 4'b1011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   function automatic logic is_iter(input logic [3:0] fn);
      return (fn == FN_MUL) || (fn == FN_DIV);
   endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider.
// lo/hi present the post-step register values, so the caller can capture the result on the done edge.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic             run_q, run_d;
   logic             op_div_q, op_div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] b_q, b_d;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;

   always_comb begin
      run_d    = run_q;
      op_div_d = op_div_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      lo_d     = lo_q;
      b_d      = b_q;
      done     = 1'b0;

      mul_sum  = {1'b0, acc_q} + {1'b0, (lo_q[0] ? b_q : {WIDTH{1'b0}})};
      div_sh   = {acc_q, lo_q[WIDTH-1]};
      div_ge   = (div_sh >= {1'b0, b_q});
      // When the trial subtract succeeds the true difference is below b, so WIDTH bits suffice.
      div_diff = div_sh[WIDTH-1:0] - b_q;

      if (start) begin
         run_d    = 1'b1;
         op_div_d = op_div;
         cnt_d    = '0;
         acc_d    = '0;
         lo_d     = a;
         b_d      = b;
      end else if (run_q) begin
         cnt_d = cnt_q + 1'b1;
         if (op_div_q) begin
            acc_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
            lo_d  = {lo_q[WIDTH-2:0], div_ge};
         end else begin
            acc_d = mul_sum[WIDTH:1];
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
         end
         if (cnt_q == LAST_CNT) begin
            run_d = 1'b0;
            done  = 1'b1;
         end
      end
   end

   assign lo = lo_d;
   assign hi = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q    <= 1'b0;
         op_div_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         lo_q     <= '0;
         b_q      <= '0;
      end else begin
         run_q    <= run_d;
         op_div_q <= op_div_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU behind a valid/ready handshake.
// state | meaning
// IDLE  | in_ready high, waiting for a request
// BUSY  | mul/div iterating, one bit per cycle
// DONE  | out_valid high, result held until out_ready
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] hi,
   output logic             zero
);

   alu_state_e       state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] c_q, c_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             zero_q, zero_d;

   logic             mdu_start;
   logic             mdu_done;
   logic [WIDTH-1:0] mdu_lo;
   logic [WIDTH-1:0] mdu_hi;
   logic [WIDTH-1:0] alu_res;

   assign mdu_start = (state_q == IDLE) && in_valid && is_iter(mode);

   alu_muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (mdu_start),
      .op_div (mode == FN_DIV),
      .a      (A),
      .b      (B),
      .done   (mdu_done),
      .lo     (mdu_lo),
      .hi     (mdu_hi)
   );

   always_comb begin
      case (mode)
         FN_AND:  alu_res = A & B;
         FN_OR:   alu_res = A | B;
         FN_XOR:  alu_res = A ^ B;
         FN_NOR:  alu_res = ~(A | B);
         FN_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         FN_NAND: alu_res = ~(A & B);
         FN_ADD:  alu_res = A + B;
         FN_SUB:  alu_res = A - B;
         default: alu_res = A;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      c_d         = c_q;
      hi_d        = hi_q;
      zero_d      = zero_q;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_ready_d = 1'b0;
               if (is_iter(mode)) begin
                  state_d = BUSY;
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  c_d         = alu_res;
                  hi_d        = '0;
                  zero_d      = (alu_res == '0);
               end
            end
         end
         BUSY: begin
            if (mdu_done) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               c_d         = mdu_lo;
               hi_d        = mdu_hi;
               zero_d      = (mdu_lo == '0);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         c_q         <= '0;
         hi_q        <= '0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         c_q         <= c_d;
         hi_q        <= hi_d;
         zero_q      <= zero_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign C         = c_q;
   assign hi        = hi_q;
   assign zero      = zero_q;

endmodule
